// File: rtl/osc_dec_avg_if.sv
// ---------------------------------------------------------------------------
// osc_dec_avg_if
// Streaming bus used on both sides of the block averager. It carries
// one sample or result per transfer, with a valid/ready handshake and an
// end-of-acquisition marker.
//   TDATA  : two's complement sample or result, DW bits
//   TVALID : producer has a word on the bus
//   TLAST  : word closes its acquisition or truncated block
//   TREADY : consumer accepts the word this cycle
// Modports: master drives data/valid/last, slave drives ready.
// ---------------------------------------------------------------------------
interface osc_dec_avg_if #(
   parameter int DW = 16
);
   logic [DW-1:0] TDATA;
   logic          TVALID;
   logic          TLAST;
   logic          TREADY;

   modport master (output TDATA, output TVALID, output TLAST, input TREADY);
   modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/osc_dec_avg.sv
// ---------------------------------------------------------------------------
// osc_dec_avg
// Block averager / decimator for calibrated oscilloscope samples. Samples
// are summed in blocks of 2^L and each block yields one rounded mean.
// A TLAST on the input closes the block early; the sum is still divided
// by 2^L and the result is flagged with TLAST.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   sti       : input sample stream (slave side)
//   sto       : output mean stream (master side), one-entry result register
//   cfg_en    : averaging enable; when low, samples are discarded
//   cfg_log2  : log2 of block length, clamped to LMAX
//   sts_cnt   : number of results handed over on sto (wraps)
// ---------------------------------------------------------------------------
module osc_dec_avg #(
   parameter int DW   = 16,
   parameter int LMAX = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   osc_dec_avg_if.slave         sti,
   osc_dec_avg_if.master        sto,
   input  logic                 cfg_en,
   input  logic [3:0]           cfg_log2,
   output logic [31:0]          sts_cnt
);

   localparam int         AW    = DW + LMAX;
   localparam int         NW    = (LMAX > 0) ? LMAX : 1;
   localparam logic [3:0] LMAX4 = 4'(LMAX);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_sum;
   logic signed [AW-1:0] rnd;
   logic signed [AW-1:0] acc_res;
   logic [NW-1:0]        n;
   logic [NW:0]          n_last;
   logic [3:0]           l_lat;
   logic [3:0]           l_cfg;
   logic [3:0]           l_cur;
   logic                 in_xfer;
   logic                 out_xfer;
   logic                 closing;
   logic                 truncated;
   logic                 sto_valid;
   logic [DW-1:0]        sto_data;
   logic                 sto_last;

   // The result register can take a new result whenever it is empty or is
   // being emptied this cycle, so input is only stalled by a blocked result.
   assign sti.TREADY = !sto_valid | sto.TREADY;
   assign sto.TVALID = sto_valid;
   assign sto.TDATA  = sto_data;
   assign sto.TLAST  = sto_last;

   // Block length selection, running sum and the rounded mean for the
   // current sample. The first sample of a block uses the live (clamped)
   // configuration; later samples use the value latched with that first
   // sample, so reconfiguration only affects the following block.
   // The rounding term plus a full block of maximum samples still fits in
   // AW bits, so the shifted result always fits in DW bits.
   always_comb begin
      l_cfg     = (cfg_log2 > LMAX4) ? LMAX4 : cfg_log2;
      l_cur     = (n == '0) ? l_cfg : l_lat;
      n_last    = ((NW+1)'(1) << l_cur) - (NW+1)'(1);
      in_xfer   = sti.TVALID & sti.TREADY;
      out_xfer  = sto_valid & sto.TREADY;
      truncated = ({1'b0, n} != n_last);
      closing   = in_xfer & cfg_en & (!truncated | sti.TLAST);
      acc_sum   = acc + {{LMAX{sti.TDATA[DW-1]}}, sti.TDATA};
      rnd       = '0;
      if (l_cur != 4'd0) begin
         rnd = AW'(1) << (l_cur - 4'd1);
      end
      acc_res   = (acc_sum + rnd) >>> l_cur;
   end

   // Accumulator, sample counter and latched block length. Disabling the
   // block clears any partial sum; a closing sample leaves the accumulator
   // empty so the next accepted sample starts a fresh block.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         n     <= '0;
         l_lat <= '0;
      end else if (!cfg_en) begin
         acc <= '0;
         n   <= '0;
      end else if (in_xfer) begin
         if (n == '0) begin
            l_lat <= l_cfg;
         end
         if (closing) begin
            acc <= '0;
            n   <= '0;
         end else begin
            acc <= acc_sum;
            n   <= n + NW'(1);
         end
      end
   end

   // One-entry result register and delivery counter. A closing sample can
   // only be accepted when the register is free or draining, so a held
   // result is never overwritten while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         sto_valid <= 1'b0;
         sto_data  <= '0;
         sto_last  <= 1'b0;
         sts_cnt   <= '0;
      end else begin
         if (out_xfer) begin
            sts_cnt <= sts_cnt + 32'd1;
         end
         if (closing) begin
            sto_valid <= 1'b1;
            sto_data  <= acc_res[DW-1:0];
            sto_last  <= sti.TLAST & truncated;
         end else if (out_xfer) begin
            sto_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_osc_dec_avg.sv
// ---------------------------------------------------------------------------
// tb_osc_dec_avg
// Self-checking bench for osc_dec_avg. A transaction-level reference model
// collects accepted samples into blocks and computes each mean with plain
// integer arithmetic; delivered results are collected from the output bus
// and compared against the model, alongside directed checks of timing,
// backpressure, enable and reset behaviour.
// ---------------------------------------------------------------------------
module tb_osc_dec_avg;

   localparam int DW   = 16;
   localparam int LMAX = 10;

   typedef struct {
      int data;
      bit last;
   } res_t;

   logic        clk;
   logic        rst;
   logic        cfg_en;
   logic [3:0]  cfg_log2;
   logic [31:0] sts_cnt;

   osc_dec_avg_if #(.DW(DW)) sti_if ();
   osc_dec_avg_if #(.DW(DW)) sto_if ();

   osc_dec_avg #(.DW(DW), .LMAX(LMAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .sti      (sti_if.slave),
      .sto      (sto_if.master),
      .cfg_en   (cfg_en),
      .cfg_log2 (cfg_log2),
      .sts_cnt  (sts_cnt)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_exp = 0;
   bit   acc_flag;
   int   blk[$];
   int   blk_l;
   res_t exp_q[$];
   res_t obs_q[$];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a scenario never returns.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: one call per cycle with the handshake outcome.
   function automatic void model_step(input bit en, input bit acc_ok, input int d,
                                      input bit lst, input int lg);
      longint sum;
      longint r;
      if (!en) begin
         blk.delete();
         return;
      end
      if (!acc_ok) return;
      if (blk.size() == 0) blk_l = (lg > LMAX) ? LMAX : lg;
      blk.push_back(d);
      if (blk.size() == (1 << blk_l) || lst) begin
         sum = 0;
         foreach (blk[i]) sum += blk[i];
         if (blk_l == 0) r = sum;
         else r = (sum + (longint'(1) << (blk_l - 1))) >>> blk_l;
         exp_q.push_back('{int'(r), blk.size() < (1 << blk_l)});
         n_exp++;
         blk.delete();
      end
   endfunction

   // Advance one clock: observe handshakes mid-cycle, feed the model, then
   // return just after the next rising edge so new inputs can be driven.
   task automatic tick();
      @(negedge clk);
      acc_flag = sti_if.TVALID && sti_if.TREADY && !rst;
      if (rst) begin
         blk.delete();
         exp_q.delete();
         obs_q.delete();
         n_exp = 0;
      end else begin
         if (sto_if.TVALID && sto_if.TREADY)
            obs_q.push_back('{int'($signed(sto_if.TDATA)), sto_if.TLAST});
         model_step(cfg_en, acc_flag, int'($signed(sti_if.TDATA)),
                    sti_if.TLAST, int'(cfg_log2));
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Offer one sample and wait (bounded) until it is accepted.
   task automatic send(input int d, input bit lst);
      sti_if.TVALID = 1'b1;
      sti_if.TDATA  = DW'(d);
      sti_if.TLAST  = lst;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (acc_flag) break;
      end
      n_chk++;
      if (!acc_flag) begin
         n_fail++;
         $display("[TB] FAIL send_timeout: sample %0d not accepted, expected accept within 100 cycles", d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_en = 1'b1;
      cfg_log2 = 4'd2;
      sto_if.TREADY = 1'b1;
      sti_if.TVALID = 1'b1;
      sti_if.TDATA = DW'(77);
      sti_if.TLAST = 1'b0;
      tick();
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b0 || sto_if.TDATA !== '0 || sto_if.TLAST !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got v=%b d=%0d l=%b, expected 0/0/0",
                  sto_if.TVALID, sto_if.TDATA, sto_if.TLAST);
      end
      n_chk++;
      if (sts_cnt !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_cnt: got %0d expected 0", sts_cnt);
      end
      n_chk++;
      if (sti_if.TREADY !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_ready: got %b expected 1", sti_if.TREADY);
      end
      sti_if.TVALID = 1'b0;
      rst = 1'b0;
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got valid %b expected 0", sto_if.TVALID);
      end
   endtask

   task automatic test_basic();
      cfg_log2 = 4'd2;
      send(1, 0);
      send(2, 0);
      send(3, 0);
      n_chk++;
      if (sto_if.TVALID !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_early: got valid %b expected 0", sto_if.TVALID);
      end
      send(4, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 3 || sto_if.TLAST !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_result: got v=%b d=%0d l=%b, expected 1/3/0",
                  sto_if.TVALID, $signed(sto_if.TDATA), sto_if.TLAST);
      end
      tick();
      n_chk++;
      if (sts_cnt !== 32'd1 || sto_if.TVALID !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_count: got cnt=%0d v=%b, expected 1/0", sts_cnt, sto_if.TVALID);
      end
   endtask

   task automatic test_extremes();
      obs_q.delete();
      exp_q.delete();
      cfg_log2 = 4'd3;
      for (int i = 0; i < 8; i++) send(-32768, 0);
      for (int i = 0; i < 8; i++) send(32767, 0);
      sti_if.TVALID = 1'b0;
      tick();
      tick();
      n_chk++;
      if (obs_q.size() !== 2) begin
         n_fail++;
         $display("[TB] FAIL extremes_count: got %0d results expected 2", obs_q.size());
      end else begin
         n_chk++;
         if (obs_q[0].data !== -32768 || obs_q[0].last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL extremes_min: got %0d/%b expected -32768/0", obs_q[0].data, obs_q[0].last);
         end
         n_chk++;
         if (obs_q[1].data !== 32767 || obs_q[1].last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL extremes_max: got %0d/%b expected 32767/0", obs_q[1].data, obs_q[1].last);
         end
      end
   endtask

   task automatic test_truncated();
      cfg_log2 = 4'd2;
      send(4, 0);
      send(4, 0);
      send(4, 1);
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 3 || sto_if.TLAST !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL trunc_result: got v=%b d=%0d l=%b, expected 1/3/1",
                  sto_if.TVALID, $signed(sto_if.TDATA), sto_if.TLAST);
      end
      for (int i = 0; i < 4; i++) send(6, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 6 || sto_if.TLAST !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL trunc_next: got v=%b d=%0d l=%b, expected 1/6/0",
                  sto_if.TVALID, $signed(sto_if.TDATA), sto_if.TLAST);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int c0;
      obs_q.delete();
      exp_q.delete();
      cfg_log2 = 4'd0;
      sto_if.TREADY = 1'b0;
      send(10, 0);
      sti_if.TDATA = DW'(20);
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (sti_if.TREADY !== 1'b0 || sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 10) begin
            n_fail++;
            $display("[TB] FAIL bp_stall: got rdy=%b v=%b d=%0d, expected 0/1/10",
                     sti_if.TREADY, sto_if.TVALID, $signed(sto_if.TDATA));
         end
         tick();
      end
      sto_if.TREADY = 1'b1;
      c0 = cyc;
      send(20, 0);
      send(30, 0);
      send(40, 0);
      send(50, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (cyc - c0 !== 4) begin
         n_fail++;
         $display("[TB] FAIL bp_throughput: got %0d cycles expected 4", cyc - c0);
      end
      tick();
      tick();
      n_chk++;
      if (obs_q.size() !== 5 || exp_q.size() !== 5) begin
         n_fail++;
         $display("[TB] FAIL bp_count: got %0d results expected 5", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
            n_fail++;
            $display("[TB] FAIL bp_result[%0d]: got %0d/%b expected %0d/%b",
                     i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_cfg_change();
      cfg_log2 = 4'd1;
      send(10, 0);
      cfg_log2 = 4'd2;
      send(20, 0);
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 15) begin
         n_fail++;
         $display("[TB] FAIL cfg_first: got v=%b d=%0d, expected 1/15",
                  sto_if.TVALID, $signed(sto_if.TDATA));
      end
      send(1, 0);
      send(2, 0);
      send(3, 0);
      n_chk++;
      if (sto_if.TVALID !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL cfg_early: got valid %b expected 0", sto_if.TVALID);
      end
      send(6, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 3) begin
         n_fail++;
         $display("[TB] FAIL cfg_second: got v=%b d=%0d, expected 1/3",
                  sto_if.TVALID, $signed(sto_if.TDATA));
      end
      tick();
   endtask

   task automatic test_enable();
      cfg_log2 = 4'd2;
      send(50, 0);
      send(50, 0);
      cfg_en = 1'b0;
      sti_if.TVALID = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         send(7, 0);
         n_chk++;
         if (sto_if.TVALID !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL en_discard[%0d]: got valid %b expected 0", i, sto_if.TVALID);
         end
      end
      cfg_en = 1'b1;
      for (int i = 0; i < 4; i++) send(2, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 2) begin
         n_fail++;
         $display("[TB] FAIL en_fresh: got v=%b d=%0d, expected 1/2",
                  sto_if.TVALID, $signed(sto_if.TDATA));
      end
      tick();
      sto_if.TREADY = 1'b0;
      for (int i = 0; i < 4; i++) send(9, 0);
      sti_if.TVALID = 1'b0;
      cfg_en = 1'b0;
      tick();
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 9) begin
         n_fail++;
         $display("[TB] FAIL en_pending: got v=%b d=%0d, expected 1/9",
                  sto_if.TVALID, $signed(sto_if.TDATA));
      end
      sto_if.TREADY = 1'b1;
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b0 || obs_q.size() == 0 || obs_q[$].data !== 9) begin
         n_fail++;
         $display("[TB] FAIL en_deliver: got v=%b, expected 0 and last delivered 9", sto_if.TVALID);
      end
      cfg_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      cfg_log2 = 4'd2;
      sto_if.TREADY = 1'b0;
      for (int i = 0; i < 4; i++) send(5, 0);
      sti_if.TVALID = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b0 || sts_cnt !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL rst_pending: got v=%b cnt=%0d, expected 0/0", sto_if.TVALID, sts_cnt);
      end
      sto_if.TREADY = 1'b1;
      send(100, 0);
      send(100, 0);
      sti_if.TVALID = 1'b0;
      rst = 1'b1;
      tick();
      n_chk++;
      if (sto_if.TVALID !== 1'b0 || sto_if.TDATA !== '0 || sto_if.TLAST !== 1'b0 || sts_cnt !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_outputs: got v=%b d=%0d l=%b cnt=%0d, expected 0/0/0/0",
                  sto_if.TVALID, sto_if.TDATA, sto_if.TLAST, sts_cnt);
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) send(8, 0);
      sti_if.TVALID = 1'b0;
      n_chk++;
      if (sto_if.TVALID !== 1'b1 || int'($signed(sto_if.TDATA)) !== 8) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_result: got v=%b d=%0d, expected 1/8",
                  sto_if.TVALID, $signed(sto_if.TDATA));
      end
      tick();
      n_chk++;
      if (sts_cnt !== 32'd1) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_cnt: got %0d expected 1", sts_cnt);
      end
   endtask

   task automatic test_random();
      bit            stall;
      logic [DW-1:0] held;
      logic          held_l;
      int            base;
      obs_q.delete();
      exp_q.delete();
      base = n_exp;
      for (int c = 0; c < 3000; c++) begin
         sto_if.TREADY = ($urandom_range(0, 3) != 0);
         sti_if.TVALID = ($urandom_range(0, 9) < 7);
         sti_if.TDATA  = DW'($urandom);
         sti_if.TLAST  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0)
            cfg_log2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
         if ($urandom_range(0, 199) == 0) cfg_en = ~cfg_en;
         stall  = sto_if.TVALID && !sto_if.TREADY;
         held   = sto_if.TDATA;
         held_l = sto_if.TLAST;
         tick();
         if (stall) begin
            n_chk++;
            if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== held || sto_if.TLAST !== held_l) begin
               n_fail++;
               $display("[TB] FAIL rand_stable: got v=%b d=%h l=%b, expected 1/%h/%b",
                        sto_if.TVALID, sto_if.TDATA, sto_if.TLAST, held, held_l);
            end
         end
      end
      sti_if.TVALID = 1'b0;
      sto_if.TREADY = 1'b1;
      cfg_en = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("[TB] FAIL rand_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
            n_fail++;
            $display("[TB] FAIL rand_result[%0d]: got %0d/%b expected %0d/%b",
                     i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
      n_chk++;
      if (sts_cnt !== 32'(n_exp)) begin
         n_fail++;
         $display("[TB] FAIL rand_sts_cnt: got %0d expected %0d (random part %0d)",
                  sts_cnt, n_exp, n_exp - base);
      end
   endtask

   // Scenario sequence.
   initial begin
      rst = 1'b1;
      cfg_en = 1'b1;
      cfg_log2 = 4'd0;
      sti_if.TVALID = 1'b0;
      sti_if.TDATA = '0;
      sti_if.TLAST = 1'b0;
      sto_if.TREADY = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_extremes();
      test_truncated();
      test_backpressure();
      test_cfg_change();
      test_enable();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
